prog_loader: RTL and testbench

- Boot-time loader that sits directly upstream of the cpu block.
- Takes a 32-bit word stream over a valid/ready handshake and writes it into the cpu's instruction and data memories through the external memory write ports.
- Checks each section against a checksum, then raises the cpu's execution enable.
- Replaces testbench-driven memory preloading so one host link can boot the core.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: unpacks a header/data/trailer word stream into the cpu's instruction and
// data memories, verifies each section's additive checksum, then enables the cpu.
module prog_loader #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [31:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [31:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {StHdr, StData, StTrl, StRun, StErr} state_e;

    state_e      state_q, state_d;
    logic        target_q, target_d;
    logic        go_q, go_d;
    logic [15:0] index_q, index_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] csum_q, csum_d;
    logic        imem_wen_q, imem_wen_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;

    logic        accept;
    logic [16:0] hdr_end;
    logic [16:0] hdr_limit;
    logic [31:0] wr_addr;

    assign s_ready    = (state_q == StHdr) || (state_q == StData) || (state_q == StTrl);
    assign busy       = (state_q == StData) || (state_q == StTrl);
    assign cpu_enable = (state_q == StRun);
    assign err        = (state_q == StErr);
    assign imem_wen   = imem_wen_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

    assign accept = s_valid && s_ready;

    // 17-bit sum so start+count can never wrap past the memory depth.
    assign hdr_end   = {3'b000, s_data[29:16]} + {1'b0, s_data[15:0]};
    assign hdr_limit = s_data[31] ? 17'(DMEM_WORDS) : 17'(IMEM_WORDS);
    assign wr_addr   = {14'b0, index_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        go_d         = go_q;
        index_d      = index_q;
        remaining_d  = remaining_q;
        csum_d       = csum_q;
        imem_wen_d   = 1'b0;
        dmem_wen_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    if (hdr_end > hdr_limit) begin
                        state_d = StErr;
                    end else begin
                        target_d    = s_data[31];
                        go_d        = s_data[30];
                        index_d     = {2'b00, s_data[29:16]};
                        remaining_d = s_data[15:0];
                        csum_d      = '0;
                        state_d     = (s_data[15:0] == 16'd0) ? StTrl : StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (target_q) begin
                        dmem_wen_d   = 1'b1;
                        dmem_addr_d  = wr_addr;
                        dmem_wdata_d = s_data;
                    end else begin
                        imem_wen_d   = 1'b1;
                        imem_addr_d  = wr_addr;
                        imem_wdata_d = s_data;
                    end
                    index_d     = index_q + 16'd1;
                    remaining_d = remaining_q - 16'd1;
                    csum_d      = csum_q + s_data;
                    if (remaining_q == 16'd1) begin
                        state_d = StTrl;
                    end
                end
            end
            StTrl: begin
                if (accept) begin
                    if (s_data != csum_q) begin
                        state_d = StErr;
                    end else begin
                        state_d = go_q ? StRun : StHdr;
                    end
                end
            end
            StRun, StErr: begin
                state_d = state_q;
            end
            default: begin
                state_d = StErr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= StHdr;
            target_q     <= 1'b0;
            go_q         <= 1'b0;
            index_q      <= '0;
            remaining_q  <= '0;
            csum_q       <= '0;
            imem_wen_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            go_q         <= go_d;
            index_q      <= index_d;
            remaining_q  <= remaining_d;
            csum_q       <= csum_d;
            imem_wen_q   <= imem_wen_d;
            dmem_wen_q   <= dmem_wen_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a section-level model is compared against every output on
// every cycle, and literal expectations at key points pin the model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic        imem_wen, dmem_wen, cpu_enable, busy, err;

    int tests = 0;
    int fails = 0;
    bit model_on = 1'b0;

    prog_loader #(
        .IMEM_WORDS(512),
        .DMEM_WORDS(1024)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .imem_addr (imem_addr),
        .imem_wen  (imem_wen),
        .imem_wdata(imem_wdata),
        .dmem_addr (dmem_addr),
        .dmem_wen  (dmem_wen),
        .dmem_wdata(dmem_wdata),
        .cpu_enable(cpu_enable),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Section-level model: phase 0 header, 1 data, 2 trailer, 3 running, 4 error.
    int          m_phase = 0;
    bit          m_dmem, m_go;
    int          m_idx, m_left;
    logic [31:0] m_sum;
    logic        e_iwen, e_dwen;
    logic [31:0] e_iaddr, e_iwd, e_daddr, e_dwd;

    always @(posedge clk) begin
        if (!arst_n) begin
            m_phase = 0;
            m_sum   = '0;
            e_iwen  = 1'b0;
            e_dwen  = 1'b0;
            e_iaddr = '0;
            e_iwd   = '0;
            e_daddr = '0;
            e_dwd   = '0;
        end else begin
            e_iwen = 1'b0;
            e_dwen = 1'b0;
            if (s_valid && m_phase <= 2) begin
                if (m_phase == 0) begin
                    int start, n, depth;
                    start = int'(s_data[29:16]);
                    n     = int'(s_data[15:0]);
                    depth = s_data[31] ? 1024 : 512;
                    if (start + n > depth) begin
                        m_phase = 4;
                    end else begin
                        m_dmem  = s_data[31];
                        m_go    = s_data[30];
                        m_idx   = start;
                        m_left  = n;
                        m_sum   = '0;
                        m_phase = (n == 0) ? 2 : 1;
                    end
                end else if (m_phase == 1) begin
                    if (m_dmem) begin
                        e_dwen  = 1'b1;
                        e_daddr = 32'(m_idx * 4);
                        e_dwd   = s_data;
                    end else begin
                        e_iwen  = 1'b1;
                        e_iaddr = 32'(m_idx * 4);
                        e_iwd   = s_data;
                    end
                    m_idx  = m_idx + 1;
                    m_left = m_left - 1;
                    m_sum  = m_sum + s_data;
                    if (m_left == 0) m_phase = 2;
                end else begin
                    if (s_data != m_sum) m_phase = 4;
                    else m_phase = m_go ? 3 : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_s_ready", 32'(s_ready), 32'(m_phase <= 2));
            chk("cyc_busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
            chk("cyc_cpu_enable", 32'(cpu_enable), 32'(m_phase == 3));
            chk("cyc_err", 32'(err), 32'(m_phase == 4));
            chk("cyc_imem_wen", 32'(imem_wen), 32'(e_iwen));
            chk("cyc_imem_addr", imem_addr, e_iaddr);
            chk("cyc_imem_wdata", imem_wdata, e_iwd);
            chk("cyc_dmem_wen", 32'(dmem_wen), 32'(e_dwen));
            chk("cyc_dmem_addr", dmem_addr, e_daddr);
            chk("cyc_dmem_wdata", dmem_wdata, e_dwd);
        end
    end

    // Returns at 1 time unit after the edge that accepted the word.
    task automatic send(input logic [31:0] w);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word 0x%08h not accepted, expected acceptance", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        arst_n   = 1'b1;
        model_on = 1'b1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);

        // IMEM load with go
        send(32'h4000_0003);
        chk("imem_busy", 32'(busy), 32'd1);
        send(32'h11);
        chk("imem_w0_wen", 32'(imem_wen), 32'd1);
        chk("imem_w0_addr", imem_addr, 32'h0);
        chk("imem_w0_data", imem_wdata, 32'h11);
        send(32'h22);
        chk("imem_w1_addr", imem_addr, 32'h4);
        send(32'h33);
        chk("imem_w2_addr", imem_addr, 32'h8);
        chk("imem_w2_data", imem_wdata, 32'h33);
        send(32'h66);
        chk("imem_run_enable", 32'(cpu_enable), 32'd1);
        chk("imem_run_ready", 32'(s_ready), 32'd0);
        idle(3);
        chk("imem_run_hold", 32'(cpu_enable), 32'd1);

        // DMEM section without go, then IMEM section with go, back to back
        do_reset();
        send(32'h8005_0002);
        send(32'hFFFF_FFFF);
        chk("dmem_w0_wen", 32'(dmem_wen), 32'd1);
        chk("dmem_w0_addr", dmem_addr, 32'h14);
        chk("dmem_w0_iwen", 32'(imem_wen), 32'd0);
        send(32'h2);
        chk("dmem_w1_addr", dmem_addr, 32'h18);
        chk("dmem_w1_data", dmem_wdata, 32'h2);
        send(32'h1);
        chk("dmem_back_hdr", 32'(s_ready), 32'd1);
        chk("dmem_no_enable", 32'(cpu_enable), 32'd0);
        send(32'h4000_0001);
        send(32'hA);
        send(32'hA);
        chk("two_sec_enable", 32'(cpu_enable), 32'd1);

        // Checksum error
        do_reset();
        send(32'h0000_0001);
        send(32'h5);
        send(32'h6);
        chk("csum_err", 32'(err), 32'd1);
        chk("csum_ready", 32'(s_ready), 32'd0);
        idle(10);
        chk("csum_no_enable", 32'(cpu_enable), 32'd0);
        chk("csum_err_sticky", 32'(err), 32'd1);

        // Bounds
        do_reset();
        send(32'h01FF_0002);
        chk("bounds_err", 32'(err), 32'd1);
        chk("bounds_no_wen", 32'(imem_wen), 32'd0);
        do_reset();
        send(32'h01FF_0001);
        chk("bounds_ok", 32'(err), 32'd0);
        send(32'hDEAD_BEEF);
        chk("bounds_last_addr", imem_addr, 32'h7FC);
        send(32'hDEAD_BEEF);
        chk("bounds_back_hdr", 32'(busy), 32'd0);

        // Gaps between data words
        do_reset();
        send(32'h4002_0003);
        idle(1);
        send(32'h1);
        chk("gap_w0_addr", imem_addr, 32'h8);
        idle(1);
        chk("gap_idle_wen", 32'(imem_wen), 32'd0);
        chk("gap_idle_addr_hold", imem_addr, 32'h8);
        send(32'h2);
        idle(2);
        send(32'h3);
        chk("gap_w2_addr", imem_addr, 32'h10);
        idle(1);
        send(32'h6);
        chk("gap_enable", 32'(cpu_enable), 32'd1);

        // Reset mid-DATA, then a zero-length section
        do_reset();
        send(32'h8000_0004);
        send(32'h7);
        send(32'h8);
        chk("mid_w1_addr", dmem_addr, 32'h4);
        do_reset();
        chk("mid_wen_dropped", 32'(dmem_wen), 32'd0);
        chk("mid_ready", 32'(s_ready), 32'd1);
        chk("mid_err", 32'(err), 32'd0);
        idle(3);
        send(32'h4000_0000);
        chk("zero_len_busy", 32'(busy), 32'd1);
        send(32'h0);
        chk("zero_len_enable", 32'(cpu_enable), 32'd1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
